// File: rtl/uart_reg_pkg.sv
// uart_reg_pkg: shared FSM states, command bytes and default response bytes for uart_reg_bridge
package uart_reg_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, READ, RD_WAIT, RESP} state_t;
  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK_DEFAULT = 8'h4B;
  localparam logic [7:0] NAK_DEFAULT = 8'h3F;
endpackage

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: UART byte stream to register bus bridge; define UART_REG_BRIDGE_TIMEOUT_EN for an inter-byte idle timeout
module uart_reg_bridge
  import uart_reg_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] ACK_BYTE = ACK_DEFAULT,
  parameter logic [7:0] NAK_BYTE = NAK_DEFAULT
) (
  input  logic       clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_dv,
  output logic [7:0] o_tx_data,
  output logic       o_tx_dv,
  input  logic       i_tx_busy,
  output logic [7:0] o_addr,
  output logic [7:0] o_wdata,
  output logic       o_we,
  output logic       o_re,
  input  logic [7:0] i_rdata,
  input  logic       i_rvalid,
  output logic       o_frame_err
);
  state_t state;
  logic is_wr;
  logic drop;
  logic timeout;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  assign drop = i_rx_dv && (state == WRITE || state == READ || state == RD_WAIT || state == RESP);
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] idle_cnt;
  logic waiting;
  assign waiting = state == ADDR || state == DATA;
  assign timeout = waiting && !i_rx_dv && idle_cnt == CW'(TIMEOUT_CYCLES - 1);
  // count idle cycles between bytes of a partially received frame
  always_ff @(posedge clk or negedge i_reset_n)
    if (!i_reset_n) idle_cnt <= '0;
    else idle_cnt <= (i_rx_dv || !waiting || timeout) ? '0 : idle_cnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  assign o_frame_err = drop | timeout;
  // frame decoder, bus strobes and response sequencing; o_tx_dv is issued on RESP entry when the transmitter is free
  always_ff @(posedge clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= IDLE;
      is_wr <= 1'b0;
      o_addr <= '0;
      o_wdata <= '0;
      o_we <= 1'b0;
      o_re <= 1'b0;
      o_tx_data <= '0;
      o_tx_dv <= 1'b0;
    end else begin
      o_we <= 1'b0;
      o_re <= 1'b0;
      o_tx_dv <= 1'b0;
      if (timeout) state <= IDLE;
      else
        case (state)
          IDLE: if (i_rx_dv) begin
            if (i_rx_data == CMD_WR || i_rx_data == CMD_RD) begin
              state <= ADDR;
              is_wr <= i_rx_data == CMD_WR;
            end else begin
              state <= RESP;
              o_tx_data <= NAK_BYTE;
              o_tx_dv <= !i_tx_busy;
            end
          end
          ADDR: if (i_rx_dv) begin
            o_addr <= i_rx_data;
            o_re <= !is_wr;
            state <= is_wr ? DATA : READ;
          end
          DATA: if (i_rx_dv) begin
            o_wdata <= i_rx_data;
            o_we <= 1'b1;
            state <= WRITE;
          end
          WRITE: begin
            o_tx_data <= ACK_BYTE;
            o_tx_dv <= !i_tx_busy;
            state <= RESP;
          end
          READ: state <= RD_WAIT;
          RD_WAIT: if (i_rvalid) begin
            o_tx_data <= i_rdata;
            o_tx_dv <= !i_tx_busy;
            state <= RESP;
          end
          RESP: if (o_tx_dv) state <= IDLE;
            else o_tx_dv <= !i_tx_busy;
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge: scoreboard bench for uart_reg_bridge; expected strobes are queued by stimulus and popped by a monitor
module tb_uart_reg_bridge;
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
  localparam int TO = 50;
`else
  localparam int TO = 100000;
`endif
  logic clk = 1'b0;
  logic i_reset_n = 1'b1;
  logic [7:0] i_rx_data = '0;
  logic i_rx_dv = 1'b0;
  logic i_tx_busy = 1'b0;
  logic [7:0] i_rdata = '0;
  logic i_rvalid = 1'b0;
  logic [7:0] o_tx_data, o_addr, o_wdata;
  logic o_tx_dv, o_we, o_re, o_frame_err;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  logic [7:0] rd_val = '0;
  typedef struct {
    logic [15:0] v;
    int c;
  } exp_t;
  exp_t q_wr[$];
  exp_t q_rd[$];
  exp_t q_tx[$];
  exp_t q_err[$];

  uart_reg_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_rx_data(i_rx_data), .i_rx_dv(i_rx_dv),
    .o_tx_data(o_tx_data), .o_tx_dv(o_tx_dv), .i_tx_busy(i_tx_busy),
    .o_addr(o_addr), .o_wdata(o_wdata), .o_we(o_we), .o_re(o_re),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic cmp(input string name, input bit empty, input exp_t e, input logic [15:0] act);
    if (empty) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected strobe actual=%h required=none (cycle %0d)", name, act, cyc);
    end else begin
      chk(name, act, e.v);
      if (e.c >= 0) chk({name, "_cycle"}, 16'(cyc), 16'(e.c));
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit emp;
    e = '{16'h0, -1};
    if (o_we) begin
      emp = q_wr.size() == 0;
      if (!emp) e = q_wr.pop_front();
      cmp("we", emp, e, {o_addr, o_wdata});
    end
    if (o_re) begin
      emp = q_rd.size() == 0;
      if (!emp) e = q_rd.pop_front();
      cmp("re", emp, e, {8'h0, o_addr});
    end
    if (o_tx_dv) begin
      emp = q_tx.size() == 0;
      if (!emp) e = q_tx.pop_front();
      cmp("tx", emp, e, {8'h0, o_tx_data});
    end
    if (o_frame_err) begin
      emp = q_err.size() == 0;
      if (!emp) e = q_err.pop_front();
      cmp("frame_err", emp, e, 16'h0);
    end
  end

  initial forever begin
    @(negedge clk);
    if (o_re) begin
      repeat (3) @(posedge clk);
      #1;
      i_rdata = rd_val;
      i_rvalid = 1'b1;
      @(posedge clk);
      #1;
      i_rvalid = 1'b0;
    end
  end

  task automatic send(input logic [7:0] b, input bit err, output int c);
    @(posedge clk);
    #1;
    i_rx_data = b;
    i_rx_dv = 1'b1;
    c = cyc;
    if (err) q_err.push_back('{16'h0, cyc});
    @(posedge clk);
    #1;
    i_rx_dv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int c2;
    #2 i_reset_n = 1'b0;
    idle(3);
    chk("rst_tx_data", {8'h0, o_tx_data}, 16'h0);
    chk("rst_addr", {8'h0, o_addr}, 16'h0);
    chk("rst_strobes", {12'h0, o_we, o_re, o_tx_dv, o_frame_err}, 16'h0);
    i_reset_n = 1'b1;
    idle(2);
    send(8'h57, 0, c);
    send(8'h10, 0, c);
    send(8'hA5, 0, c);
    q_wr.push_back('{16'h10A5, c + 1});
    q_tx.push_back('{16'h004B, c + 2});
    idle(6);
    rd_val = 8'h3C;
    send(8'h52, 0, c);
    send(8'h22, 0, c);
    q_rd.push_back('{16'h0022, c + 1});
    q_tx.push_back('{16'h003C, c + 5});
    idle(10);
    chk("addr_hold", {8'h0, o_addr}, 16'h0022);
    chk("wdata_hold", {8'h0, o_wdata}, 16'h00A5);
    send(8'hFF, 0, c);
    q_tx.push_back('{16'h003F, c + 1});
    idle(5);
    i_tx_busy = 1'b1;
    send(8'h00, 0, c);
    idle(5);
    send(8'h52, 1, c2);
    idle(12);
    chk("nak_held", {8'h0, o_tx_data}, 16'h003F);
    i_tx_busy = 1'b0;
    q_tx.push_back('{16'h003F, cyc + 1});
    idle(5);
    rd_val = 8'h99;
    send(8'h52, 0, c);
    send(8'h40, 0, c);
    q_rd.push_back('{16'h0040, c + 1});
    q_tx.push_back('{16'h0099, c + 5});
    send(8'h57, 1, c2);
    idle(10);
    send(8'h57, 0, c);
    send(8'h11, 0, c);
    send(8'h22, 0, c);
    q_wr.push_back('{16'h1122, c + 1});
    q_tx.push_back('{16'h004B, c + 2});
    idle(6);
    send(8'h57, 0, c);
    send(8'h10, 0, c);
    i_reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_addr", {8'h0, o_addr}, 16'h0);
    chk("midrst_wdata", {8'h0, o_wdata}, 16'h0);
    chk("midrst_tx_data", {8'h0, o_tx_data}, 16'h0);
    chk("midrst_strobes", {12'h0, o_we, o_re, o_tx_dv, o_frame_err}, 16'h0);
    idle(2);
    i_reset_n = 1'b1;
    idle(2);
    rd_val = 8'h5A;
    send(8'h52, 0, c);
    send(8'h10, 0, c);
    q_rd.push_back('{16'h0010, c + 1});
    q_tx.push_back('{16'h005A, c + 5});
    idle(10);
`ifdef UART_REG_BRIDGE_TIMEOUT_EN
    send(8'h57, 0, c);
    q_err.push_back('{16'h0, c + 50});
    idle(60);
    rd_val = 8'h77;
    send(8'h52, 0, c);
    send(8'h33, 0, c);
    q_rd.push_back('{16'h0033, c + 1});
    q_tx.push_back('{16'h0077, c + 5});
    idle(10);
`endif
    for (int i = 0; i < 300 && (q_wr.size() + q_rd.size() + q_tx.size() + q_err.size()) != 0; i++) @(posedge clk);
    @(negedge clk);
    chk("q_wr_drained", 16'(q_wr.size()), 16'h0);
    chk("q_rd_drained", 16'(q_rd.size()), 16'h0);
    chk("q_tx_drained", 16'(q_tx.size()), 16'h0);
    chk("q_err_drained", 16'(q_err.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
